mac_accum_ctrl: RTL and testbench

- Sequential wrapper that sits between a streaming operand source and the team's combinational 8x8 unsigned array multiplier.
- Accepts operand pairs over a valid/ready handshake and registers them onto the multiplier inputs.
- Captures the 16-bit product and accumulates the products of a frame, which is terminated by in_last.
- Presents the frame sum, term count and overflow flag on a valid/ready output handshake.

---
 rtl/mac_accum_ctrl.sv | 79 +++++++
 tb/tb_mac_accum_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_ctrl.sv
// mac_accum_ctrl: handshake wrapper that feeds an 8x8 multiplier and accumulates each frame's products
module mac_accum_ctrl #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic [7:0]       mul_a,
    output logic [7:0]       mul_b,
    input  logic [15:0]      mul_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic v1, last1, v2, last2, accept, done;
    logic [15:0] prod_q;
    logic [ACC_W:0] sum;
    assign in_ready  = rst_n && (state == IDLE || state == RUN);
    assign accept    = in_valid && in_ready;
    assign out_valid = state == DONE;
    assign done      = out_valid && out_ready;
    assign sum       = {1'b0, out_sum} + {{(ACC_W-15){1'b0}}, prod_q};
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = in_last ? DRAIN : RUN;
        else if (state == DRAIN && v2 && last2)
            state_nxt = DONE;
        else if (done)
            state_nxt = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mul_a   <= '0;
            mul_b   <= '0;
            v1      <= 1'b0;
            last1   <= 1'b0;
            v2      <= 1'b0;
            last2   <= 1'b0;
            prod_q  <= '0;
            out_sum <= '0;
            out_cnt <= '0;
            out_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            v1    <= accept;
            last1 <= accept && in_last;
            v2    <= v1;
            last2 <= last1;
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
            end
            if (v1)
                prod_q <= mul_prod;
            if (done) begin
                out_sum <= '0;
                out_cnt <= '0;
                out_ovf <= 1'b0;
            end else if (v2) begin
                out_sum <= (SAT && sum[ACC_W]) ? '1 : sum[ACC_W-1:0];
                out_cnt <= out_cnt + CNT_W'(out_cnt != '1);
                if (sum[ACC_W])
                    out_ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mac_accum_ctrl.sv
// tb_mac_accum_ctrl: four configurations run in lockstep against a scoreboard of modelled frame results
module tb_mac_accum_ctrl;
    localparam logic [3:0][5:0] AW = {6'd24, 6'd16, 6'd16, 6'd24};
    localparam logic [3:0][5:0] CW = {6'd2, 6'd8, 6'd8, 6'd8};
    localparam logic [3:0]      SV = 4'b1011;
    typedef struct packed {
        logic [3:0][31:0] sum;
        logic [3:0][7:0]  cnt;
        logic [3:0]       ovf;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0] in_a = '0, in_b = '0;
    logic [7:0] ma0, mb0, ma1, mb1, ma2, mb2, ma3, mb3;
    logic [23:0] s0, s3;
    logic [15:0] s1, s2;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;
    logic [3:0] gv, gr, go;
    logic [31:0] gs [4];
    logic [7:0] gc [4];
    logic [7:0] gm [4];
    exp_t sb[$];
    logic [7:0] fa[$], fb[$];
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    mac_accum_ctrl #(.ACC_W(24), .CNT_W(8), .SAT(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(gr[0]),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma0), .mul_b(mb0), .mul_prod(16'(ma0 * mb0)),
        .out_valid(gv[0]), .out_ready(out_ready), .out_sum(s0), .out_cnt(c0), .out_ovf(go[0]));
    mac_accum_ctrl #(.ACC_W(16), .CNT_W(8), .SAT(1'b1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(gr[1]),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma1), .mul_b(mb1), .mul_prod(16'(ma1 * mb1)),
        .out_valid(gv[1]), .out_ready(out_ready), .out_sum(s1), .out_cnt(c1), .out_ovf(go[1]));
    mac_accum_ctrl #(.ACC_W(16), .CNT_W(8), .SAT(1'b0)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(gr[2]),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma2), .mul_b(mb2), .mul_prod(16'(ma2 * mb2)),
        .out_valid(gv[2]), .out_ready(out_ready), .out_sum(s2), .out_cnt(c2), .out_ovf(go[2]));
    mac_accum_ctrl #(.ACC_W(24), .CNT_W(2), .SAT(1'b1)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(gr[3]),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(ma3), .mul_b(mb3), .mul_prod(16'(ma3 * mb3)),
        .out_valid(gv[3]), .out_ready(out_ready), .out_sum(s3), .out_cnt(c3), .out_ovf(go[3]));
    assign gs[0] = 32'(s0);
    assign gs[1] = 32'(s1);
    assign gs[2] = 32'(s2);
    assign gs[3] = 32'(s3);
    assign gc[0] = c0;
    assign gc[1] = c1;
    assign gc[2] = c2;
    assign gc[3] = 8'(c3);
    assign gm[0] = ma0;
    assign gm[1] = ma1;
    assign gm[2] = ma2;
    assign gm[3] = ma3;
    task automatic add(input logic [7:0] a, input logic [7:0] b);
        fa.push_back(a);
        fb.push_back(b);
    endtask
    // Models the frame for every configuration, pushes the result, then drives the terms.
    task automatic send_frame();
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            longint acc = 0, s, lim = longint'(1) << AW[k];
            int cnt = 0, cmax = (1 << CW[k]) - 1;
            logic ovf = 1'b0;
            for (int i = 0; i < fa.size(); i++) begin
                s = acc + longint'(fa[i]) * longint'(fb[i]);
                if (s >= lim) begin
                    ovf = 1'b1;
                    acc = SV[k] ? lim - 1 : s - lim;
                end else
                    acc = s;
                cnt = cnt < cmax ? cnt + 1 : cnt;
            end
            e.sum[k] = 32'(acc);
            e.cnt[k] = 8'(cnt);
            e.ovf[k] = ovf;
        end
        sb.push_back(e);
        for (int i = 0; i < fa.size(); i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = fa[i];
            in_b = fb[i];
            in_last = i == fa.size() - 1;
            for (int w = 0; w < 20 && !gr[0]; w++) @(negedge clk);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        fa.delete();
        fb.delete();
    endtask
    task automatic collect();
        exp_t e;
        int w = 0;
        while (!gv[0] && w < 50) begin
            @(negedge clk);
            w++;
        end
        e = sb.pop_front();
        total++;
        if (gv !== 4'hf) begin
            bad++;
            $display("FAIL out_valid timeout: got %b want 1111", gv);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            total += 3;
            if (gs[k] !== e.sum[k]) begin bad++; $display("FAIL sum[%0d]: got %0d want %0d", k, gs[k], e.sum[k]); end
            if (gc[k] !== e.cnt[k]) begin bad++; $display("FAIL cnt[%0d]: got %0d want %0d", k, gc[k], e.cnt[k]); end
            if (go[k] !== e.ovf[k]) begin bad++; $display("FAIL ovf[%0d]: got %0d want %0d", k, go[k], e.ovf[k]); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total += 3;
        if (gv !== 4'h0) begin bad++; $display("FAIL post_handshake_valid: got %b want 0000", gv); end
        if (gr !== 4'hf) begin bad++; $display("FAIL post_handshake_ready: got %b want 1111", gr); end
        if (gs[0] !== 32'd0 || gc[0] !== 8'd0) begin bad++; $display("FAIL post_handshake_clear: got sum %0d cnt %0d want 0 0", gs[0], gc[0]); end
    endtask
    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (gv[k] !== 1'b0 || gr[k] !== 1'b0 || gs[k] !== 32'd0 || gc[k] !== 8'd0 || go[k] !== 1'b0 || gm[k] !== 8'd0) begin
                bad++;
                $display("FAIL reset[%0d]: got v%b r%b s%0d c%0d o%b a%0d want all 0", k, gv[k], gr[k], gs[k], gc[k], go[k], gm[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (gr !== 4'hf) begin bad++; $display("FAIL ready_after_reset: got %b want 1111", gr); end
    endtask
    task automatic test_basic();
        out_ready = 1'b1;
        add(8'd3, 8'd4);
        add(8'd5, 8'd6);
        add(8'd255, 8'd255);
        send_frame();
        total += 2;
        if (gv !== 4'h0) begin bad++; $display("FAIL valid_t0: got %b want 0000", gv); end
        if (gr !== 4'h0) begin bad++; $display("FAIL drain_ready: got %b want 0000", gr); end
        @(negedge clk);
        total++;
        if (gv !== 4'h0) begin bad++; $display("FAIL valid_t1: got %b want 0000", gv); end
        @(negedge clk);
        total++;
        if (gv !== 4'hf) begin bad++; $display("FAIL valid_t2: got %b want 1111", gv); end
        total++;
        if (s0 !== 24'd65067) begin bad++; $display("FAIL basic_sum: got %0d want 65067", s0); end
        collect();
    endtask
    task automatic test_overflow();
        add(8'd255, 8'd255);
        add(8'd255, 8'd255);
        send_frame();
        @(negedge clk);
        @(negedge clk);
        total += 2;
        if (s1 !== 16'd65535 || go[1] !== 1'b1) begin bad++; $display("FAIL sat16: got %0d/%b want 65535/1", s1, go[1]); end
        if (s2 !== 16'd64514 || go[2] !== 1'b1) begin bad++; $display("FAIL wrap16: got %0d/%b want 64514/1", s2, go[2]); end
        collect();
    endtask
    task automatic test_single();
        add(8'd0, 8'd200);
        send_frame();
        collect();
        add(8'd1, 8'd1);
        send_frame();
        collect();
    endtask
    task automatic test_backpressure();
        exp_t e;
        add(8'd7, 8'd9);
        send_frame();
        for (int w = 0; w < 20 && !gv[0]; w++) @(negedge clk);
        e = sb[0];
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_last = 1'b1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            @(negedge clk);
            total += 4;
            if (gv !== 4'hf) begin bad++; $display("FAIL bp_valid[%0d]: got %b want 1111", i, gv); end
            if (gr !== 4'h0) begin bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, gr); end
            if (gs[0] !== e.sum[0] || gc[0] !== e.cnt[0]) begin bad++; $display("FAIL bp_stable[%0d]: got %0d/%0d want %0d/%0d", i, gs[0], gc[0], e.sum[0], e.cnt[0]); end
            if (gm[0] !== 8'd7) begin bad++; $display("FAIL bp_mul_a[%0d]: got %0d want 7", i, gm[0]); end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        collect();
    endtask
    task automatic test_cnt_sat();
        for (int i = 0; i < 5; i++) add(8'd1, 8'd1);
        send_frame();
        collect();
    endtask
    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_a = 8'd10;
        in_b = 8'd20;
        @(negedge clk);
        in_a = 8'd30;
        in_b = 8'd40;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (s0 !== 24'd1400) begin bad++; $display("FAIL partial_sum: got %0d want 1400", s0); end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (gv[k] !== 1'b0 || gr[k] !== 1'b0 || gs[k] !== 32'd0 || gc[k] !== 8'd0 || go[k] !== 1'b0 || gm[k] !== 8'd0) begin
                bad++;
                $display("FAIL async_reset[%0d]: got v%b r%b s%0d c%0d o%b a%0d want all 0", k, gv[k], gr[k], gs[k], gc[k], go[k], gm[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        add(8'd2, 8'd3);
        send_frame();
        collect();
    endtask
    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_single();
        test_backpressure();
        test_cnt_sat();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
